// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and helpers for the bit-serial subtractor
// Purpose: FSM state type shared by the serial arithmetic blocks.
// Ports: none (package).
package serial_subtractor_pkg;

  // Fixed 2-bit encoding so a future serial_adder can reuse the same values.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width: ceil(log2(width)), never less than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
// Purpose: diff = a ^ b ^ bin, bout = borrow out of (a - b - bin).
// Ports:
//   bout  out 1  borrow out
//   diff  out 1  difference bit
//   a     in  1  minuend bit
//   b     in  1  subtrahend bit
//   bin   in  1  borrow in
module full_subtractor (
  output logic bout,
  output logic diff,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic d1;
  logic b1;
  logic b2;

  // First half-subtractor stage: a - b.
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // Second half-subtractor stage: (a - b) - bin.
  assign diff = d1 ^ bin;
  assign b2   = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, WIDTH cycles per result
// Purpose: computes diff = a - b mod 2^WIDTH and bout = (a < b) with one full-subtractor cell.
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      synchronous active-low reset
//   start  in  1      request, sampled only when not busy
//   a      in  WIDTH  minuend, captured on accepted start
//   b      in  WIDTH  subtrahend, captured on accepted start
//   busy   out 1      subtraction in progress
//   done   out 1      one-cycle pulse, diff/bout valid
//   diff   out WIDTH  registered difference, held until next done
//   bout   out 1      registered final borrow, held with diff
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             bit_diff;
  logic             bit_bout;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_cell (
    .bout (bit_bout),
    .diff (bit_diff),
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (borrow_q)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at the LSB.
  // Written as a loop so WIDTH=1 needs no zero-width slice.
  always_comb begin
    res_shift = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      res_shift[i] = res_q[i+1];
    end
    res_shift[WIDTH-1] = bit_diff;
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        res_d    = res_shift;
        borrow_d = bit_bout;
        if (cnt_q == CNT_LAST) begin
          // Final bit: the shifted result is complete this cycle.
          diff_d  = res_shift;
          bout_d  = bit_bout;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1)
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
  } vec8_t;

  typedef struct {
    logic [0:0] a;
    logic [0:0] b;
    logic [0:0] diff;
    logic       bout;
  } vec1_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch one WIDTH=8 operation and wait (bounded) for done.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     output int lat, output int busy_cnt, output int ok);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0; busy_cnt = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done8) begin
        ok = 1;
        break;
      end
      if (busy8) busy_cnt++;
    end
  endtask

  task automatic op1(input logic [0:0] av, input logic [0:0] bv,
                     output int lat, output int ok);
    @(negedge clk);
    a1 = av; b1 = bv; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = 0; ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (done1) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    vec8_t v8[8];
    vec1_t v1[4];
    vec8_t b2b[3];
    int lat, bcnt, ok, extra;

    v8[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    v8[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
    v8[2] = '{8'hFF,  8'hFF,  8'd0,   1'b0};
    v8[3] = '{8'd0,   8'd1,   8'hFF,  1'b1};
    v8[4] = '{8'd200, 8'd100, 8'd100, 1'b0};
    v8[5] = '{8'd0,   8'd0,   8'd0,   1'b0};
    v8[6] = '{8'd1,   8'd255, 8'd2,   1'b1};
    v8[7] = '{8'd128, 8'd127, 8'd1,   1'b0};

    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
    v1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    v1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

    b2b[0] = '{8'd50,  8'd20,  8'd30,  1'b0};
    b2b[1] = '{8'd3,   8'd10,  8'd249, 1'b1};
    b2b[2] = '{8'd170, 8'd85,  8'd85,  1'b0};

    rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy8", busy8, 0);
    chk("reset_done8", done8, 0);
    chk("reset_diff8", diff8, 0);
    chk("reset_bout8", bout8, 0);
    chk("reset_busy1", busy1, 0);
    chk("reset_done1", done1, 0);
    rst_n = 1'b1;

    // Table-driven single operations.
    for (int i = 0; i < 8; i++) begin
      op8(v8[i].a, v8[i].b, lat, bcnt, ok);
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      chk($sformatf("vec%0d_diff", i), diff8, v8[i].diff);
      chk($sformatf("vec%0d_bout", i), bout8, v8[i].bout);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done8, 0);
    end

    // Back-to-back: start held high, operands changed in each DONE cycle, scrambled while busy.
    @(negedge clk);
    a8 = b2b[0].a; b8 = b2b[0].b; start8 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1 a8 = 8'h5A; b8 = 8'hC3;
      lat = 0; ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        lat++;
        if (done8) begin
          ok = 1;
          break;
        end
      end
      chk($sformatf("b2b%0d_done", j), ok, 1);
      chk($sformatf("b2b%0d_period", j), lat, 9);
      chk($sformatf("b2b%0d_diff", j), diff8, b2b[j].diff);
      chk($sformatf("b2b%0d_bout", j), bout8, b2b[j].bout);
      if (j < 2) begin
        a8 = b2b[j+1].a; b8 = b2b[j+1].b;
      end else begin
        start8 = 1'b0;
      end
    end
    @(negedge clk);

    // Start pulse during RUN is ignored.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd37; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin
        ok = 1;
        break;
      end
    end
    chk("ignore_done", ok, 1);
    chk("ignore_diff", diff8, 63);
    chk("ignore_bout", bout8, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    chk("ignore_no_extra", extra, 0);
    chk("ignore_diff_held", diff8, 63);

    // Reset mid-RUN aborts and clears outputs.
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd9; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_bout", bout8, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    chk("abort_no_done", extra, 0);
    op8(8'd0, 8'd1, lat, bcnt, ok);
    chk("after_abort_done", ok, 1);
    chk("after_abort_latency", lat, 9);
    chk("after_abort_diff", diff8, 255);
    chk("after_abort_bout", bout8, 1);

    // WIDTH=1 truth table.
    for (int i = 0; i < 4; i++) begin
      op1(v1[i].a, v1[i].b, lat, ok);
      chk($sformatf("w1_%0d_done", i), ok, 1);
      chk($sformatf("w1_%0d_latency", i), lat, 2);
      chk($sformatf("w1_%0d_diff", i), diff1, v1[i].diff);
      chk($sformatf("w1_%0d_bout", i), bout1, v1[i].bout);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
